input_vc_unit: RTL

//  Next-generation router input stage. Pops flits from the upstream input FIFO, computes the output port (XY or YX)
//  and buffers each flit in one of NUM_VC virtual-channel FIFOs. Presents per-VC head route/valid to the switch

---
 rtl/noc_pkg.sv | 46 ++++
 rtl/input_vc_unit_vc_fifo.sv | 55 +++++
 rtl/input_vc_unit.sv | 124 ++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: output-port codes, flit field offsets and dimension-ordered route functions.
package noc_pkg;

    localparam int unsigned ROUTE_W     = 3;
    localparam int unsigned COORD_CMP_W = 32;
    localparam int unsigned VC_ID_LSB   = 0;

    localparam logic [ROUTE_W-1:0] PORT_N       = 3'b000;
    localparam logic [ROUTE_W-1:0] PORT_S       = 3'b001;
    localparam logic [ROUTE_W-1:0] PORT_E       = 3'b010;
    localparam logic [ROUTE_W-1:0] PORT_W       = 3'b011;
    localparam logic [ROUTE_W-1:0] PORT_L       = 3'b100;
    localparam logic [ROUTE_W-1:0] PORT_INVALID = 3'b111;

    // Destination X occupies the top coordinate field, destination Y the one below it.
    function automatic int unsigned dest_x_msb(input int unsigned dsize);
        return dsize - 1;
    endfunction

    function automatic int unsigned dest_y_msb(input int unsigned dsize, input int unsigned rrsize);
        return dsize - rrsize - 1;
    endfunction

    function automatic logic [ROUTE_W-1:0] xy_route(
        input logic [COORD_CMP_W-1:0] dx,
        input logic [COORD_CMP_W-1:0] dy,
        input logic [COORD_CMP_W-1:0] rx,
        input logic [COORD_CMP_W-1:0] ry
    );
        if (dx != rx)      return (dx > rx) ? PORT_E : PORT_W;
        else if (dy != ry) return (dy > ry) ? PORT_S : PORT_N;
        else               return PORT_L;
    endfunction

    function automatic logic [ROUTE_W-1:0] yx_route(
        input logic [COORD_CMP_W-1:0] dx,
        input logic [COORD_CMP_W-1:0] dy,
        input logic [COORD_CMP_W-1:0] rx,
        input logic [COORD_CMP_W-1:0] ry
    );
        if (dy != ry)      return (dy > ry) ? PORT_S : PORT_N;
        else if (dx != rx) return (dx > rx) ? PORT_E : PORT_W;
        else               return PORT_L;
    endfunction

endpackage

// File: rtl/input_vc_unit_vc_fifo.sv
// Single virtual-channel FIFO: circular buffer with occupancy count, head is first-word-fall-through.
module vc_fifo #(
    parameter int unsigned WIDTH = 35,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    // Storage needs no reset; an empty count makes stale entries invisible.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == CNT_W'(0));

endmodule

// File: rtl/input_vc_unit.sv
// Router input stage: routes incoming flits, buffers them per virtual channel and dequeues on allocator grant.
module input_vc_unit
    import noc_pkg::*;
#(
    parameter int unsigned MSB_SLOT  = 5,
    parameter int unsigned DSIZE     = 32,
    parameter int unsigned RRSIZE    = 1 << (MSB_SLOT - 2),
    parameter int unsigned NUM_VC    = 2,
    parameter int unsigned VC_DEPTH  = 4,
    parameter logic [2:0]  PORT      = 3'b000,
    parameter int unsigned ROUTER_X  = 1,
    parameter int unsigned ROUTER_Y  = 1,
    parameter int unsigned ALGORITHM = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DSIZE-1:0]        data_in,
    input  logic                    input_empty,
    output logic                    input_read,
    output logic [NUM_VC-1:0]       vc_valid,
    output logic [3*NUM_VC-1:0]     vc_route,
    input  logic [NUM_VC-1:0]       vc_grant,
    output logic [DSIZE-1:0]        data_out,
    output logic [2:0]              out_port,
    output logic                    data_valid,
    output logic [NUM_VC-1:0]       credit_out,
    output logic                    drop,
    output logic                    grant_err
);

    localparam int unsigned VCW     = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
    localparam int unsigned ENTRY_W = DSIZE + ROUTE_W;
    localparam int unsigned DX_MSB  = dest_x_msb(DSIZE);
    localparam int unsigned DY_MSB  = dest_y_msb(DSIZE, RRSIZE);

    logic [RRSIZE-1:0]  dest_x;
    logic [RRSIZE-1:0]  dest_y;
    logic [ROUTE_W-1:0] route;
    logic [VCW-1:0]     vc_id;
    logic               vc_ok;
    logic               uturn;
    logic               sel_full;

    logic [NUM_VC-1:0]  fifo_full;
    logic [NUM_VC-1:0]  fifo_empty;
    logic [NUM_VC-1:0]  wr_en;
    logic [NUM_VC-1:0]  pop;
    logic [ENTRY_W-1:0] heads [NUM_VC];
    logic [ENTRY_W-1:0] head_sel;
    logic               grant_legal;

    // Output-port computation on the upstream head flit.
    assign dest_x = data_in[DX_MSB -: RRSIZE];
    assign dest_y = data_in[DY_MSB -: RRSIZE];
    assign route  = (ALGORITHM != 0)
                  ? yx_route(COORD_CMP_W'(dest_x), COORD_CMP_W'(dest_y),
                             COORD_CMP_W'(ROUTER_X), COORD_CMP_W'(ROUTER_Y))
                  : xy_route(COORD_CMP_W'(dest_x), COORD_CMP_W'(dest_y),
                             COORD_CMP_W'(ROUTER_X), COORD_CMP_W'(ROUTER_Y));

    // Flits bouncing back out of their arrival port, or naming a nonexistent VC, are discarded.
    assign vc_id    = data_in[VC_ID_LSB +: VCW];
    assign vc_ok    = (32'(vc_id) < NUM_VC);
    assign uturn    = ((route == PORT) && (route != PORT_L)) || !vc_ok;
    assign sel_full = vc_ok ? fifo_full[vc_id] : 1'b1;

    assign input_read = reset && !input_empty && (uturn || !sel_full);

    assign grant_legal = $onehot(vc_grant) && (|(vc_grant & vc_valid));
    assign pop         = grant_legal ? vc_grant : '0;

    genvar v;
    generate
        for (v = 0; v < NUM_VC; v++) begin : g_vc
            assign wr_en[v] = input_read && !uturn && (vc_id == VCW'(v));

            vc_fifo #(
                .WIDTH (ENTRY_W),
                .DEPTH (VC_DEPTH)
            ) u_fifo (
                .clk     (clk),
                .reset   (reset),
                .wr_en   (wr_en[v]),
                .wr_data ({data_in, route}),
                .rd_en   (pop[v]),
                .head    (heads[v]),
                .full    (fifo_full[v]),
                .empty   (fifo_empty[v])
            );

            assign vc_valid[v]       = !fifo_empty[v];
            assign vc_route[3*v +: 3] = fifo_empty[v] ? PORT_INVALID : heads[v][ROUTE_W-1:0];
        end
    endgenerate

    // Pop is one-hot or zero, so an OR of masked heads selects the granted entry.
    always_comb begin
        head_sel = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            head_sel = head_sel | (heads[i] & {ENTRY_W{pop[i]}});
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out   <= '0;
            out_port   <= PORT_INVALID;
            data_valid <= 1'b0;
            credit_out <= '0;
            drop       <= 1'b0;
            grant_err  <= 1'b0;
        end else begin
            data_valid <= grant_legal;
            credit_out <= pop;
            drop       <= input_read && uturn;
            grant_err  <= (|vc_grant) && !grant_legal;
            if (grant_legal) begin
                data_out <= head_sel[ENTRY_W-1 -: DSIZE];
                out_port <= head_sel[ROUTE_W-1:0];
            end
        end
    end

endmodule
